// File: rtl/pkt_framer_pkg.sv
// Shared constants for the packet framer: one-hot frame states,
// header fill values and the injection request record.
package pkt_framer_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'b001;
  localparam logic [STATE_W-1:0] S_DATA    = 3'b010;
  localparam logic [STATE_W-1:0] S_RECOVER = 3'b100;

  // Header/idle words are built by replicating these across WORD_SIZE.
  localparam logic HDR_FILL     = 1'b1;
  localparam logic HDR_ERR_FILL = 1'b0;

  typedef struct packed {
    logic pend;
    logic hdr;
  } inj_t;

endpackage

// File: rtl/pkt_framer_fifo_sync.sv
// Synchronous FIFO with show-ahead read data and a registered occupancy count.
module fifo_sync #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pkt_framer.sv
// Frames buffered payloads as {header, payload, seq}, one frame per clock,
// with idle frames in gaps and on-demand header/sequence error injection.
module pkt_framer
  import pkt_framer_pkg::*;
#(
  parameter int BUS_SIZE   = 32,
  parameter int WORD_SIZE  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BUS_SIZE-2*WORD_SIZE-1:0]   payload_in,
  input  logic                              payload_valid,
  output logic                              payload_ready,
  input  logic                              tx_en,
  input  logic                              inj_req,
  input  logic                              inj_hdr,
  output logic                              inj_busy,
  output logic [BUS_SIZE-1:0]               data_out,
  output logic                              frame_valid,
  output logic [STATE_W-1:0]                dbg_state
);

  localparam int PAYLOAD_SIZE = BUS_SIZE - 2*WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] HDR_WORD = {WORD_SIZE{HDR_FILL}};
  localparam logic [WORD_SIZE-1:0] ERR_WORD = {WORD_SIZE{HDR_ERR_FILL}};
  localparam logic [BUS_SIZE-1:0]  IDLE_FRAME = {HDR_WORD, {(BUS_SIZE-WORD_SIZE){1'b0}}};

  logic [STATE_W-1:0]      state;
  logic [STATE_W-1:0]      next_state;
  logic [WORD_SIZE-1:0]    seq_cnt;
  logic [WORD_SIZE-1:0]    seq_word;
  logic [WORD_SIZE-1:0]    hdr_word;
  logic [PAYLOAD_SIZE-1:0] head;
  inj_t                    inj;
  logic                    corrupt;
  logic                    corrupt_q;
  logic                    load_data;
  logic                    full;
  logic                    empty;
  logic                    run;

  // Handshake: a payload transfers on any rising edge where payload_valid and
  // payload_ready are both high; ready depends only on registered state.
  assign payload_ready = run && !full;
  assign inj_busy      = inj.pend;
  assign dbg_state     = state;

  fifo_sync #(.WIDTH(PAYLOAD_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (payload_valid && payload_ready),
    .wr_data (payload_in),
    .pop     (load_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // A corrupted frame is always followed by one recovery idle frame.
  always_comb begin
    next_state = S_IDLE;
    if (corrupt_q)            next_state = S_RECOVER;
    else if (tx_en && !empty) next_state = S_DATA;
  end

  assign load_data = (next_state == S_DATA);
  assign corrupt   = load_data && inj.pend;

  always_comb begin
    hdr_word = HDR_WORD;
    seq_word = seq_cnt;
    if (corrupt && inj.hdr) hdr_word = ERR_WORD;
    if (corrupt && !inj.hdr)
      seq_word = (seq_cnt == '1) ? WORD_SIZE'(1) : seq_cnt + WORD_SIZE'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      seq_cnt     <= WORD_SIZE'(1);
      data_out    <= '0;
      frame_valid <= 1'b0;
      corrupt_q   <= 1'b0;
      inj         <= '0;
      run         <= 1'b0;
    end else begin
      run         <= 1'b1;
      state       <= next_state;
      corrupt_q   <= corrupt;
      frame_valid <= load_data;
      if (load_data) begin
        data_out <= {hdr_word, head, seq_word};
        seq_cnt  <= seq_cnt + WORD_SIZE'(1);
      end else begin
        data_out <= IDLE_FRAME;
        seq_cnt  <= WORD_SIZE'(1);
      end
      if (corrupt)                inj.pend <= 1'b0;
      else if (inj_req && !inj.pend) begin
        inj.pend <= 1'b1;
        inj.hdr  <= inj_hdr;
      end
    end
  end

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer with default parameters (32-bit frames, 4-bit words).
module tb_pkt_framer;

  logic        clk;
  logic        reset;
  logic [23:0] payload_in;
  logic        payload_valid;
  logic        payload_ready;
  logic        tx_en;
  logic        inj_req;
  logic        inj_hdr;
  logic        inj_busy;
  logic [31:0] data_out;
  logic        frame_valid;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  pkt_framer dut (
    .clk           (clk),
    .reset         (reset),
    .payload_in    (payload_in),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .tx_en         (tx_en),
    .inj_req       (inj_req),
    .inj_hdr       (inj_hdr),
    .inj_busy      (inj_busy),
    .data_out      (data_out),
    .frame_valid   (frame_valid),
    .dbg_state     (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp, input logic fv);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_fv"}, {31'd0, frame_valid}, {31'd0, fv});
  endtask

  initial begin
    logic [31:0] e;
    reset = 1'b1; payload_in = '0; payload_valid = 1'b0;
    tx_en = 1'b0; inj_req = 1'b0; inj_hdr = 1'b0;

    // reset state
    #1 reset = 1'b0;
    #1;
    check("rst_data", data_out, 32'h0);
    check("rst_fv", {31'd0, frame_valid}, 32'd0);
    check("rst_ready", {31'd0, payload_ready}, 32'd0);
    check("rst_busy", {31'd0, inj_busy}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd1);
    #15 reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      check_frame("idle_after_rst", 32'hF000_0000, 1'b0);
      check("idle_ready", {31'd0, payload_ready}, 32'd1);
    end

    // two pushes, one cycle latency each
    tx_en = 1'b1;
    payload_in = 24'hABCDEF; payload_valid = 1'b1;
    step();
    check_frame("two_p0", 32'hF000_0000, 1'b0);
    payload_in = 24'h123456;
    step();
    check_frame("two_p1", 32'hFABC_DEF1, 1'b1);
    payload_valid = 1'b0;
    step();
    check_frame("two_p2", 32'hF123_4562, 1'b1);
    step();
    check_frame("two_idle", 32'hF000_0000, 1'b0);

    // 17 back-to-back payloads, sequence wraps through 0
    for (int j = 0; j < 17; j++) begin
      payload_in = 24'h100000 + 24'(j * 3);
      payload_valid = 1'b1;
      exp_q.push_back({4'hF, payload_in, 4'(j + 1)});
      step();
      if (j > 0) begin
        e = exp_q.pop_front();
        check_frame("stream", e, 1'b1);
      end
    end
    payload_valid = 1'b0;
    step();
    e = exp_q.pop_front();
    check_frame("stream_last", e, 1'b1);
    step();
    check_frame("stream_idle", 32'hF000_0000, 1'b0);

    // fill with tx_en low, then drain
    tx_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      payload_in = 24'h200000 + 24'(k); payload_valid = 1'b1;
      step();
      check_frame("hold_idle", 32'hF000_0000, 1'b0);
    end
    check("full_ready", {31'd0, payload_ready}, 32'd0);
    payload_in = 24'h200004;
    step();
    check("full_ready2", {31'd0, payload_ready}, 32'd0);
    check_frame("full_idle", 32'hF000_0000, 1'b0);
    tx_en = 1'b1;
    step();
    check_frame("drain1", 32'hF200_0001, 1'b1);
    check("drain_ready", {31'd0, payload_ready}, 32'd1);
    step();
    payload_valid = 1'b0;
    check_frame("drain2", 32'hF200_0012, 1'b1);
    step();
    check_frame("drain3", 32'hF200_0023, 1'b1);
    step();
    check_frame("drain4", 32'hF200_0034, 1'b1);
    step();
    check_frame("drain5", 32'hF200_0045, 1'b1);
    step();
    check_frame("drain_idle", 32'hF000_0000, 1'b0);

    // header error at seq 3
    payload_in = 24'h300001; payload_valid = 1'b1;
    step();
    check_frame("ih_idle", 32'hF000_0000, 1'b0);
    payload_in = 24'h300002;
    step();
    check_frame("ih_s1", 32'hF300_0011, 1'b1);
    payload_in = 24'h300003; inj_req = 1'b1; inj_hdr = 1'b1;
    step();
    check_frame("ih_s2", 32'hF300_0022, 1'b1);
    check("ih_busy", {31'd0, inj_busy}, 32'd1);
    inj_req = 1'b0; inj_hdr = 1'b0; payload_in = 24'h300004;
    step();
    check_frame("ih_bad", 32'h0300_0033, 1'b1);
    check("ih_busy_clr", {31'd0, inj_busy}, 32'd0);
    payload_in = 24'h300005;
    step();
    check_frame("ih_recover", 32'hF000_0000, 1'b0);
    check("ih_state", {29'd0, dbg_state}, 32'd4);
    payload_valid = 1'b0;
    step();
    check_frame("ih_next", 32'hF300_0041, 1'b1);
    step();
    check_frame("ih_next2", 32'hF300_0052, 1'b1);
    step();
    check_frame("ih_idle2", 32'hF000_0000, 1'b0);

    // sequence error at seq_cnt 15
    for (int s = 0; s < 16; s++) begin
      payload_in = 24'h500000 + 24'(s); payload_valid = 1'b1;
      inj_req = (s == 14); inj_hdr = 1'b0;
      step();
      if (s >= 1) begin
        e = {4'hF, 24'h500000 + 24'(s - 1), (s == 15) ? 4'h1 : 4'(s)};
        check_frame("is_stream", e, 1'b1);
      end
    end
    payload_valid = 1'b0; inj_req = 1'b0;
    step();
    check_frame("is_recover", 32'hF000_0000, 1'b0);
    step();
    check_frame("is_next", 32'hF500_00F1, 1'b1);
    step();
    check_frame("is_idle", 32'hF000_0000, 1'b0);

    // reset mid-burst with FIFO contents and a pending injection
    tx_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      payload_in = 24'h600000 + 24'(k); payload_valid = 1'b1;
      inj_req = (k == 1); inj_hdr = 1'b1;
      step();
    end
    payload_valid = 1'b0; inj_req = 1'b0;
    check("mr_busy", {31'd0, inj_busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mr_data", data_out, 32'h0);
    check("mr_fv", {31'd0, frame_valid}, 32'd0);
    check("mr_busy0", {31'd0, inj_busy}, 32'd0);
    check("mr_ready", {31'd0, payload_ready}, 32'd0);
    #1 reset = 1'b1;
    tx_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_frame("mr_empty", 32'hF000_0000, 1'b0);
    end
    check("mr_busy_after", {31'd0, inj_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
